// File: rtl/mmio_bridge.sv
// CPU memory-bus bridge: splits byte accesses between RAM and the I/O page,
// and owns the UART TX FIFO, RX holding register, cycle counter and stop sequence.
module mmio_bridge #(
    parameter int          TX_DEPTH    = 16,
    parameter int          FULL_MARGIN = 2,
    parameter int          RAM_AW      = 17,
    parameter logic [31:0] CNT_RST     = 32'h0000_0000
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [31:0]       cpu_a,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_din,
    output logic              io_buffer_full,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [RAM_AW-1:0] ram_a,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              prog_done
);

    localparam int             PW       = $clog2(TX_DEPTH);
    localparam logic [PW:0]    DEPTH_V  = (PW+1)'(TX_DEPTH);
    localparam logic [PW:0]    MARGIN_V = (PW+1)'(FULL_MARGIN);

    typedef enum logic [2:0] {
        SEL_ZERO, SEL_RAM, SEL_RX, SEL_CNT0, SEL_CNT1, SEL_CNT2, SEL_CNT3
    } rd_sel_t;

    typedef enum logic [1:0] {ST_RUN, ST_PUSH, ST_DRAIN, ST_DONE} state_t;

    state_t      r_state, w_state_nx;
    rd_sel_t     r_rd_sel, w_rd_sel_nx;
    logic [7:0]  r_mem [TX_DEPTH];
    logic [PW:0] r_wptr, r_rptr;
    logic        r_full;
    logic        r_tx_overflow;
    logic        r_rx_full;
    logic [7:0]  r_rx_data;
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_cnt_snap;

    logic        w_io, w_a_tx, w_a_cnt, w_act, w_wr_run;
    logic        w_usr_push, w_stop_cmd, w_rx_rd, w_snap_rd;
    logic        w_fsm_push, w_force_full;
    logic        w_push_req, w_push, w_pop, w_empty, w_fifo_full;
    logic [7:0]  w_push_data;
    logic [PW:0] w_count, w_count_nx, w_free_nx;
    logic        w_unused;

    assign w_unused = ^cpu_a[31:18];

    // Address decode; every side effect is qualified by rdy_in
    assign w_io       = (cpu_a[17:16] == 2'b11);
    assign w_a_tx     = (cpu_a[17:0] == 18'h30000);
    assign w_a_cnt    = (cpu_a[17:2] == 16'hC001);
    assign w_act      = rdy_in & w_io;
    assign w_wr_run   = w_act & cpu_wr & (r_state == ST_RUN);
    assign w_usr_push = w_wr_run & w_a_tx & (cpu_dout != 8'h00);
    assign w_stop_cmd = w_wr_run & w_a_cnt & (cpu_a[1:0] == 2'b00);
    assign w_rx_rd    = w_act & !cpu_wr & w_a_tx;
    assign w_snap_rd  = w_act & !cpu_wr & w_a_cnt & (cpu_a[1:0] == 2'b00);

    assign ram_en    = !w_io & rdy_in;
    assign ram_wr    = cpu_wr & !w_io;
    assign ram_a     = cpu_a[RAM_AW-1:0];
    assign ram_wdata = cpu_dout;

    // TX FIFO; the stop marker bypasses the zero filter
    assign w_count     = r_wptr - r_rptr;
    assign w_empty     = (r_wptr == r_rptr);
    assign w_fifo_full = (w_count == DEPTH_V);
    assign w_push_req  = w_usr_push | w_fsm_push;
    assign w_push_data = w_fsm_push ? 8'h00 : cpu_dout;
    assign w_push      = w_push_req & !w_fifo_full;
    assign w_pop       = !w_empty & tx_ready;
    assign w_count_nx  = w_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    assign w_free_nx   = DEPTH_V - w_count_nx;

    assign tx_valid = !w_empty;
    assign tx_data  = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wptr[PW-1:0]] <= w_push_data;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_full        <= 1'b0;
            r_tx_overflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_usr_push & w_fifo_full) r_tx_overflow <= 1'b1;
            // Built from next-cycle occupancy so the flag lines up with the push
            r_full <= (w_free_nx <= MARGIN_V) | (w_state_nx != ST_RUN);
        end
    end

    // Stop sequence FSM
    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= ST_RUN;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_RUN:   if (w_stop_cmd) w_state_nx = ST_PUSH;
            ST_PUSH:  if (rdy_in & !w_fifo_full) w_state_nx = ST_DRAIN;
            ST_DRAIN: if (rdy_in & w_empty) w_state_nx = ST_DONE;
            default:  w_state_nx = ST_DONE;
        endcase
    end

    always_comb begin
        w_fsm_push   = (r_state == ST_PUSH) & rdy_in;
        w_force_full = (r_state != ST_RUN);
        prog_done    = (r_state == ST_DONE);
    end

    assign io_buffer_full = r_full | w_force_full;

    // RX holding register; a fresh byte wins over a same-cycle read clear
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rx_full <= 1'b0;
            r_rx_data <= 8'h00;
        end else if (rx_valid) begin
            r_rx_full <= 1'b1;
            r_rx_data <= rx_data;
        end else if (w_rx_rd) begin
            r_rx_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cyc_cnt  <= CNT_RST;
            r_cnt_snap <= 32'h0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'h1;
            if (w_snap_rd) r_cnt_snap <= r_cyc_cnt;
        end
    end

    // Read path: remember the source, mux it out one cycle later
    always_comb begin
        w_rd_sel_nx = SEL_ZERO;
        if (!cpu_wr) begin
            if (!w_io) begin
                w_rd_sel_nx = SEL_RAM;
            end else if (w_a_tx) begin
                w_rd_sel_nx = r_rx_full ? SEL_RX : SEL_ZERO;
            end else if (w_a_cnt) begin
                case (cpu_a[1:0])
                    2'd0:    w_rd_sel_nx = SEL_CNT0;
                    2'd1:    w_rd_sel_nx = SEL_CNT1;
                    2'd2:    w_rd_sel_nx = SEL_CNT2;
                    default: w_rd_sel_nx = SEL_CNT3;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)      r_rd_sel <= SEL_ZERO;
        else if (rdy_in) r_rd_sel <= w_rd_sel_nx;
    end

    always_comb begin
        cpu_din = 8'h00;
        case (r_rd_sel)
            SEL_RAM:  cpu_din = ram_rdata;
            SEL_RX:   cpu_din = r_rx_data;
            SEL_CNT0: cpu_din = r_cnt_snap[7:0];
            SEL_CNT1: cpu_din = r_cnt_snap[15:8];
            SEL_CNT2: cpu_din = r_cnt_snap[23:16];
            SEL_CNT3: cpu_din = r_cnt_snap[31:24];
            default:  cpu_din = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Randomized bench for mmio_bridge: RAM scoreboard, UART byte queues,
// cycle-count arithmetic and stop/freeze/reset scenarios.
module tb_mmio_bridge;

    localparam logic [31:0] WRAP_INIT = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy, cpu_wr, tx_ready, rx_valid;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout, rx_data, ram_rdata;
    logic [7:0]  cpu_din, tx_data, ram_wdata;
    logic        iobf, ram_en, ram_wr, tx_valid, prog_done;
    logic [16:0] ram_a;
    logic [7:0]  cpu_din2, tx_data2, ram_wdata2;
    logic        iobf2, ram_en2, ram_wr2, tx_valid2, prog_done2;
    logic [16:0] ram_a2;

    mmio_bridge u_dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .cpu_a(cpu_a), .cpu_dout(cpu_dout),
        .cpu_wr(cpu_wr), .cpu_din(cpu_din), .io_buffer_full(iobf), .ram_en(ram_en),
        .ram_wr(ram_wr), .ram_a(ram_a), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .prog_done(prog_done)
    );

    mmio_bridge #(.CNT_RST(WRAP_INIT)) u_wrap (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .cpu_a(cpu_a), .cpu_dout(cpu_dout),
        .cpu_wr(cpu_wr), .cpu_din(cpu_din2), .io_buffer_full(iobf2), .ram_en(ram_en2),
        .ram_wr(ram_wr2), .ram_a(ram_a2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata),
        .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .prog_done(prog_done2)
    );

    int n_chk = 0;
    int n_err = 0;

    // External RAM with one-cycle registered read
    logic [7:0] mem [0:131071];
    initial ram_rdata = 8'h00;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) mem[ram_a] <= ram_wdata;
            else        ram_rdata <= mem[ram_a];
        end
    end

    // Bytes actually taken by the UART
    logic [7:0] got_q[$];
    always @(negedge clk) if (tx_valid && tx_ready) got_q.push_back(tx_data);

    // Edge bookkeeping: counter value = edges since the last reset edge
    int g_cyc = 0;
    int r_edge = 0;
    always @(posedge clk) begin
        g_cyc++;
        if (rst) r_edge = g_cyc;
    end

    task automatic tick; @(posedge clk); #1; endtask
    task automatic idle; cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00; endtask

    task automatic do_reset;
        rst = 1'b1; rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; idle();
        tick(); tick();
        rst = 1'b0;
        got_q.delete();
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        cpu_a = a; cpu_dout = d; cpu_wr = 1'b1;
        tick();
        idle();
    endtask

    task automatic rd(input logic [31:0] a, output logic [7:0] d1, output logic [7:0] d2);
        cpu_a = a; cpu_wr = 1'b0;
        tick();
        idle();
        @(negedge clk);
        d1 = cpu_din; d2 = cpu_din2;
        #1;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_data = d; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        tx_ready = 1'b1;
        for (int k = 0; k < budget && tx_valid; k++) tick();
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; rdy = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; idle();
        tick();
        @(negedge clk);
        n_chk++;
        if ({cpu_din, iobf, tx_valid, prog_done} !== 11'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got din=%h full=%b txv=%b done=%b, want 00/0/0/0",
                     cpu_din, iobf, tx_valid, prog_done);
        end
        #1;
        do_reset();
    endtask

    task automatic test_ram;
        logic [7:0] exp_mem [int];
        logic [7:0] d1, d2;
        int a;
        do_reset();
        wr(32'h100, 8'h5A);
        cpu_a = 32'h100; cpu_wr = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({ram_en, ram_wr, ram_a} !== {1'b1, 1'b0, 17'h100}) begin
            n_err++;
            $display("FAIL ram_strobe: got en=%b wr=%b a=%h, want 1/0/00100", ram_en, ram_wr, ram_a);
        end
        tick(); idle();
        @(negedge clk);
        n_chk++;
        if (cpu_din !== 8'h5A) begin
            n_err++;
            $display("FAIL ram_read_5a: got %h want 5a", cpu_din);
        end
        #1;
        exp_mem[32'h100] = 8'h5A;
        for (int i = 0; i < 16; i++) begin
            a = int'($urandom_range(0, 17'h1FFFF));
            exp_mem[a] = 8'($urandom);
            wr(32'(a), exp_mem[a]);
        end
        foreach (exp_mem[k]) begin
            rd(32'(k), d1, d2);
            n_chk++;
            if (d1 !== exp_mem[k]) begin
                n_err++;
                $display("FAIL ram_rand @%h: got %h want %h", k, d1, exp_mem[k]);
            end
        end
    endtask

    task automatic test_uart_out;
        logic [7:0] exp_q[$];
        logic [7:0] d;
        do_reset();
        tx_ready = 1'b1;
        wr(32'h30000, 8'h48); wr(32'h30000, 8'h00); wr(32'h30000, 8'h69);
        repeat (4) tick();
        n_chk++;
        if (got_q.size() != 2 || got_q[0] !== 8'h48 || got_q[1] !== 8'h69) begin
            n_err++;
            $display("FAIL uart_basic: got %0d bytes, want 48 69", got_q.size());
        end
        got_q.delete();
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 50 && iobf; k++) begin tx_ready = 1'b1; tick(); end
            d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            tx_ready = 1'($urandom);
            wr(32'h30000, d);
            if (d != 8'h00) exp_q.push_back(d);
        end
        drain(100);
        n_chk++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL uart_rand_len: got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_chk++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL uart_rand[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        n_chk++;
        if (u_dut.r_tx_overflow !== 1'b0) begin
            n_err++;
            $display("FAIL uart_no_overflow: got %b want 0", u_dut.r_tx_overflow);
        end
    endtask

    task automatic test_back_pressure;
        logic [7:0] exp_q[$];
        logic [7:0] d;
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            d = 8'($urandom_range(1, 255));
            wr(32'h30000, d);
            if (i <= 16) exp_q.push_back(d);
            if (i >= 12 && i <= 14) begin
                n_chk++;
                if (iobf !== (i >= 14)) begin
                    n_err++;
                    $display("FAIL bp_full_after_%0d: got %b want %b", i, iobf, i >= 14);
                end
            end
            if (i >= 16) begin
                n_chk++;
                if (u_dut.r_tx_overflow !== (i == 17)) begin
                    n_err++;
                    $display("FAIL bp_overflow_after_%0d: got %b want %b", i, u_dut.r_tx_overflow, i == 17);
                end
            end
        end
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        n_chk++;
        if (iobf !== 1'b1) begin
            n_err++;
            $display("FAIL bp_one_pop: got %b want 1", iobf);
        end
        tx_ready = 1'b1; tick(); tick(); tx_ready = 1'b0;
        n_chk++;
        if (iobf !== 1'b0) begin
            n_err++;
            $display("FAIL bp_three_pops: got %b want 0", iobf);
        end
        drain(40);
        n_chk++;
        if (got_q != exp_q) begin
            n_err++;
            $display("FAIL bp_contents: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_rx;
        logic [7:0] held, d1, d2;
        bit         full;
        do_reset();
        full = 1'b0; held = 8'h00;
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < int'($urandom_range(1, 2)); p++) begin
                held = 8'($urandom); full = 1'b1;
                rx_pulse(held);
            end
            rd(32'h30000, d1, d2);
            n_chk++;
            if (d1 !== (full ? held : 8'h00)) begin
                n_err++;
                $display("FAIL rx_read[%0d]: got %h want %h", i, d1, full ? held : 8'h00);
            end
            full = 1'b0;
            rd(32'h30000, d1, d2);
            n_chk++;
            if (d1 !== 8'h00) begin
                n_err++;
                $display("FAIL rx_empty[%0d]: got %h want 00", i, d1);
            end
        end
        rd(32'h30010, d1, d2);
        n_chk++;
        if (d1 !== 8'h00) begin
            n_err++;
            $display("FAIL unmapped_read: got %h want 00", d1);
        end
    endtask

    task automatic test_counter;
        logic [31:0] e, e2, s1, s2;
        logic [7:0]  d1, d2;
        do_reset();
        while (g_cyc - r_edge < 100) tick();
        e = 32'(g_cyc - r_edge);
        e2 = WRAP_INIT + e;
        for (int b = 0; b < 4; b++) begin
            rd(32'h30004 + 32'(b), d1, d2);
            s1[8*b +: 8] = d1; s2[8*b +: 8] = d2;
            repeat ($urandom_range(0, 20)) tick();
        end
        n_chk++;
        if (s1 !== 32'd100 || s1 !== e) begin
            n_err++;
            $display("FAIL cnt_snap_100: got %h want %h", s1, e);
        end
        n_chk++;
        if (s2 !== e2) begin
            n_err++;
            $display("FAIL cnt_snap_wrapinst: got %h want %h", s2, e2);
        end
        // Back-to-back snapshots straddling the 0xFFFFFFFF -> 0 roll-over
        do_reset();
        for (int i = 0; i < 6; i++) begin
            e = 32'(g_cyc - r_edge);
            e2 = WRAP_INIT + e;
            rd(32'h30004, d1, d2);
            n_chk++;
            if (d1 !== e[7:0] || d2 !== e2[7:0]) begin
                n_err++;
                $display("FAIL cnt_wrap[%0d]: got %h/%h want %h/%h", i, d1, d2, e[7:0], e2[7:0]);
            end
        end
    endtask

    task automatic test_stop;
        logic [7:0] exp_q[$];
        bit         seen;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'($urandom_range(1, 255)));
            wr(32'h30000, exp_q[i]);
        end
        exp_q.push_back(8'h00);
        wr(32'h30004, 8'($urandom));
        n_chk++;
        if (iobf !== 1'b1) begin
            n_err++;
            $display("FAIL stop_full_forced: got %b want 1", iobf);
        end
        tx_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (got_q.size() == 4 && !tx_valid) seen = 1'b1;
        end
        n_chk++;
        if (!seen || prog_done !== 1'b0) begin
            n_err++;
            $display("FAIL stop_drain: drained=%b done=%b, want 1/0", seen, prog_done);
        end
        @(negedge clk);
        n_chk++;
        if (prog_done !== 1'b1) begin
            n_err++;
            $display("FAIL stop_done: got %b want 1", prog_done);
        end
        #1;
        n_chk++;
        if (got_q != exp_q) begin
            n_err++;
            $display("FAIL stop_bytes: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end
        wr(32'h30000, 8'h55);
        repeat (3) tick();
        @(negedge clk);
        n_chk++;
        if (tx_valid !== 1'b0 || prog_done !== 1'b1) begin
            n_err++;
            $display("FAIL stop_terminal: got txv=%b done=%b want 0/1", tx_valid, prog_done);
        end
        #1;
    endtask

    task automatic test_freeze_reset;
        logic [7:0] rb, d1, d2;
        do_reset();
        rdy = 1'b0;
        cpu_a = 32'h30000; cpu_dout = 8'h77; cpu_wr = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ram_en !== 1'b0) begin
            n_err++;
            $display("FAIL freeze_ram_en: got %b want 0", ram_en);
        end
        tick(); idle();
        rb = 8'($urandom_range(1, 255));
        rx_pulse(rb);
        tick();
        @(negedge clk);
        n_chk++;
        if (tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL freeze_no_push: got %b want 0", tx_valid);
        end
        #1;
        rdy = 1'b1;
        rd(32'h30000, d1, d2);
        n_chk++;
        if (d1 !== rb) begin
            n_err++;
            $display("FAIL freeze_rx_capture: got %h want %h", d1, rb);
        end
        // Reset while draining
        for (int i = 0; i < 3; i++) wr(32'h30000, 8'($urandom_range(1, 255)));
        wr(32'h30004, 8'h01);
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({tx_valid, prog_done, iobf} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_in_drain: got txv=%b done=%b full=%b want 0/0/0", tx_valid, prog_done, iobf);
        end
        #1;
        wr(32'h30000, 8'h11);
        @(negedge clk);
        n_chk++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
            n_err++;
            $display("FAIL reset_run_again: got txv=%b data=%h want 1/11", tx_valid, tx_data);
        end
        #1;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_uart_out();
        test_back_pressure();
        test_rx();
        test_counter();
        test_stop();
        test_freeze_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits directly downstream of the cpu top-level memory bus (mem_a/mem_dout/mem_din/mem_wr/io_buffer_full).
- Routes each byte access either to the 128 KB RAM or to the I/O space (a[17:16]==2'b11).
- Owns the UART transmit FIFO, the receive byte holding register, the free-running cycle counter and the program-stop sequence.
- Presents the one-cycle read latency and the io_buffer_full back-pressure the cpu expects.

Parameters:
TX_DEPTH, 16, UART transmit FIFO depth in bytes (power of two, at least 4).
FULL_MARGIN, 2, io_buffer_full asserts when free TX slots <= FULL_MARGIN.
RAM_AW, 17, RAM byte-address width.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; when low, freezes all state except cyc_cnt and the UART drain
cpu_a  input  32  byte address from cpu (only [17:0] decoded)
cpu_dout  input  8  write data from cpu
cpu_wr  input  1  1 = write, 0 = read
cpu_din  output  8  read data to cpu, valid the cycle after the read address
io_buffer_full  output  1  TX back-pressure to cpu
ram_en  output  1  RAM access strobe
ram_wr  output  1  RAM write enable
ram_a  output  RAM_AW  RAM address
ram_wdata  output  8  RAM write data
ram_rdata  input  8  RAM read data (registered in RAM, 1-cycle latency)
tx_valid  output  1  byte available to UART transmitter
tx_data  output  8  byte to transmit
tx_ready  input  1  UART accepts tx_data this cycle
rx_valid  input  1  UART received byte strobe (1 cycle)
rx_data  input  8  received byte
prog_done  output  1  program stopped and TX FIFO fully drained

Behaviour:
- Decode: io = cpu_a[17:16]==2'b11; otherwise RAM. ram_en = !io & rdy_in (combinational); ram_a = cpu_a[RAM_AW-1:0]; ram_wr = cpu_wr & !io; ram_wdata = cpu_dout.
- Read path: register rd_sel (RAM / RX / CNT0..CNT3 / ZERO) on each rdy cycle. cpu_din is driven combinationally from rd_sel the next cycle: ram_rdata, rx byte, or cnt_snap byte. Unmapped I/O reads return 0x00.
- 0x30000 write:
  - Data 0x00 is ignored.
  - Otherwise push to the TX FIFO.
  - A push while the FIFO is full is dropped and sets sticky tx_overflow, a debug-only internal flag.
- 0x30000 read: returns the held RX byte and clears rx_full the same cycle. If rx_full=0, returns 0x00. A new rx_valid while rx_full=1 overwrites the held byte.
- 0x30004 read:
  - Latches cnt_snap <= cyc_cnt.
  - Returns byte 0 (little-endian).
  - Reads of 0x30005/6/7 return snap bytes 1/2/3 without re-latching.
- cyc_cnt: 32-bit, +1 every clock after reset (counts regardless of rdy_in), wraps 0xFFFFFFFF -> 0.
- 0x30004 write: the stop command. The FSM moves RUN -> STOP_PUSH.
- Stop FSM states:
  - RUN.
  - STOP_PUSH: push 0x00 into the TX FIFO, bypassing the zero filter. Retry while full. Then go to DRAIN.
  - DRAIN: wait until FIFO empty and !tx_valid pending, then go to DONE.
  - DONE: prog_done=1, all further cpu writes to I/O ignored; terminal until reset.
- TX FIFO: ptr width log2(TX_DEPTH)+1.
  - tx_valid = !empty; tx_data = head entry.
  - Pop on tx_valid & tx_ready; a pop proceeds even when rdy_in=0.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- io_buffer_full = (TX_DEPTH - count) <= FULL_MARGIN, registered. It is also forced to 1 in STOP_PUSH/DRAIN/DONE.
- rdy_in=0: no decode side effects; rd_sel holds; RX capture still occurs.
- Reset values:
  - Outputs: cpu_din=0, io_buffer_full=0, tx_valid=0, prog_done=0.
  - State: FIFO empty, rx_full=0, cyc_cnt=0, cnt_snap=0, FSM=RUN, rd_sel=ZERO.
- Reset mid-operation discards FIFO contents and any stop in progress.

Test Plan:
- RAM read: cpu_a=0x00100, ram_rdata=0x5A next cycle -> cpu_din=0x5A one cycle after the address; ram_en=1, ram_wr=0.
- UART out: write 0x48, 0x00, 0x69 to 0x30000 with tx_ready=1 -> tx_data sequence 0x48, 0x69 only; tx_overflow=0.
- Back-pressure (TX_DEPTH=16, FULL_MARGIN=2): tx_ready=0, push 14 bytes -> io_buffer_full=1 the cycle after the 14th push. 17th push dropped and tx_overflow=1; after one pop, full still 1; after three pops, full=0.
- Counter: 100 cycles after reset, read 0x30004..0x30007 -> bytes form snapshot value 100 (0x64,0,0,0) regardless of the delay between byte reads. Preload cyc_cnt=0xFFFFFFFF -> next value 0.
- Stop: FIFO holds 3 bytes, write 0x30004 with tx_ready=1 -> tx emits 3 bytes then 0x00, prog_done=1 the cycle after drain. A subsequent 0x30000 write produces no tx_valid.
- Freeze/reset: rdy_in=0 during a 0x30000 write -> no push. Reset asserted in DRAIN -> FIFO empty, prog_done=0, FSM RUN next cycle.
